// File: rtl/mmio_io_ctrl_if.sv
// CPU data-port / DRAM bus seen by the MMIO controller.
// The master side is the CPU plus DRAM, and the slave side is the controller.
interface mmio_io_ctrl_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        dram_we;
  logic [31:0] dram_rdata;

  modport master (output addr, we, wdata, dram_rdata, input rdata, dram_we);
  modport slave  (input addr, we, wdata, dram_rdata, output rdata, dram_we);
endinterface

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller: decodes the IO window and steers DRAM write enable and load data.
// Also owns the 7-seg scanner, LED register, debounced switches and tick timer.
module mmio_io_ctrl #(
  parameter logic [31:0] IO_BASE      = 32'hFFFF_F000,
  parameter int          NUM_DIGITS   = 8,
  parameter int          SCAN_DIV     = 20000,
  parameter int          SW_WIDTH     = 24,
  parameter int          LED_WIDTH    = 24,
  parameter int          DEBOUNCE_CYC = 16,
  parameter int          TICK_DIV     = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  mmio_io_ctrl_if.slave         bus,
  output logic [NUM_DIGITS-1:0] led_en,
  output logic [7:0]            seg,
  input  logic [SW_WIDTH-1:0]   device_sw,
  output logic [LED_WIDTH-1:0]  device_led
);

  localparam logic [19:0] IO_PAGE = IO_BASE[31:12];
  localparam logic [11:0] OFF_SEG_DATA = 12'h000;
  localparam logic [11:0] OFF_SEG_MASK = 12'h004;
  localparam logic [11:0] OFF_TIMER    = 12'h020;
  localparam logic [11:0] OFF_LED      = 12'h060;
  localparam logic [11:0] OFF_SW       = 12'h070;

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [31:0]           seg_data;
  logic [NUM_DIGITS-1:0] seg_mask;
  logic [31:0]           timer;
  logic [SCAN_W-1:0]     scan_cnt;
  logic [DIG_W-1:0]      digit_idx;
  logic [SW_WIDTH-1:0]   sw_meta, sw_sync, sw_stable;
  logic [DEB_W-1:0]      deb_cnt;
  logic [TICK_W-1:0]     tick_cnt;

  logic        io_hit;
  logic [11:0] offset;
  logic        io_wr;
  logic [31:0] io_rdata;

  assign io_hit      = (bus.addr[31:12] == IO_PAGE);
  assign offset      = bus.addr[11:0];
  assign io_wr       = bus.we & io_hit;
  assign bus.dram_we = bus.we & ~io_hit;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    io_rdata = '0;
    case (offset)
      OFF_SEG_DATA: io_rdata = seg_data;
      OFF_SEG_MASK: io_rdata = 32'(seg_mask);
      OFF_TIMER:    io_rdata = timer;
      OFF_LED:      io_rdata = 32'(device_led);
      OFF_SW:       io_rdata = 32'(sw_stable);
      default:      io_rdata = '0;
    endcase
  end

  assign bus.rdata = io_hit ? io_rdata : bus.dram_rdata;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  logic [3:0] cur_nibble;
  assign cur_nibble = seg_data[{digit_idx, 2'b00} +: 4];

  // CPU-visible registers
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_data   <= '0;
      seg_mask   <= '0;
      device_led <= '0;
    end else if (io_wr) begin
      if (offset == OFF_SEG_DATA) seg_data   <= bus.wdata;
      if (offset == OFF_SEG_MASK) seg_mask   <= bus.wdata[NUM_DIGITS-1:0];
      if (offset == OFF_LED)      device_led <= bus.wdata[LED_WIDTH-1:0];
    end
  end

  // Timer: a CPU write takes priority over the tick and restarts the prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer    <= '0;
      tick_cnt <= '0;
    end else if (io_wr && offset == OFF_TIMER) begin
      timer    <= bus.wdata;
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
      timer    <= timer + 32'd1;
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Scanner; outputs are registered from the current digit, so they trail the index by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      led_en    <= '1;
      seg       <= 8'hFF;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (seg_mask[digit_idx]) begin
        led_en <= ~(NUM_DIGITS'(1) << digit_idx);
        seg    <= hex_to_seg(cur_nibble);
      end else begin
        led_en <= '1;
        seg    <= 8'hFF;
      end
    end
  end

  // Switches: two-flop synchroniser, then a vector-wide debounce.
  // NOTE: only control/state flops have a reset; there are no memories here to leave unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      sw_stable <= '0;
      deb_cnt   <= '0;
    end else begin
      sw_meta <= device_sw;
      sw_sync <= sw_meta;
      if (sw_sync == sw_stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEBOUNCE_CYC - 1)) begin
        sw_stable <= sw_sync;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

endmodule
